// File: rtl/truth_table_sequencer_if.sv
// Port bundle for truth_table_sequencer: sweep control, golden table, DUT-under-test
// drive/return and the captured results. state_dbg exposes the sequencer FSM state.
interface truth_table_sequencer_if;
  // start is a request sampled on the rising edge; it is accepted only when busy is low,
  // and any start seen while busy is high is dropped without effect (no queuing).
  logic        start;
  logic [15:0] expected;
  logic        y;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        fail_valid;
  logic [1:0]  state_dbg;

  modport master (
    output start, expected, y,
    input  abcd, busy, done, pass, truth_table, mismatch_count,
           first_fail_idx, fail_valid, state_dbg
  );

  modport slave (
    input  start, expected, y,
    output abcd, busy, done, pass, truth_table, mismatch_count,
           first_fail_idx, fail_valid, state_dbg
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 ABCD vectors, captures Y per vector and grades it against a golden table.
// Optional MISMATCH_HALT_EN: stop the sweep at the first mismatching vector.
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  index;
  logic [3:0]  settle_cnt;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        fail_valid;
  logic        pass;

  logic        mismatch;
  logic [4:0]  count_next;
  logic        halt_now;

  assign mismatch   = (bus.y != bus.expected[index]);
  assign count_next = mismatch_count + {4'd0, mismatch};

`ifdef MISMATCH_HALT_EN
  assign halt_now = mismatch;
`else
  assign halt_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      index          <= 4'd0;
      settle_cnt     <= 4'd0;
      truth_table    <= 16'd0;
      mismatch_count <= 5'd0;
      first_fail_idx <= 4'd0;
      fail_valid     <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state          <= ST_APPLY;
            index          <= 4'd0;
            settle_cnt     <= 4'd0;
            truth_table    <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail_idx <= 4'd0;
            fail_valid     <= 1'b0;
            pass           <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          truth_table[index] <= bus.y;
          if (mismatch) begin
            mismatch_count <= count_next;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= index;
            end
          end
          // pass is graded on entry to DONE so it is already valid in the done cycle
          if (index == 4'd15 || halt_now) begin
            state <= ST_DONE;
            pass  <= (count_next == 5'd0);
          end else begin
            index <= index + 4'd1;
            state <= ST_APPLY;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.abcd           = (state == ST_APPLY || state == ST_SAMPLE) ? index : 4'd0;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = pass;
  assign bus.truth_table    = truth_table;
  assign bus.mismatch_count = mismatch_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.fail_valid     = fail_valid;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: sweep-level reference model compared every cycle,
// directed scenarios with literal results, randomized sweeps, and an SETTLE_CYCLES=1 abcd trace.
module tb_truth_table_sequencer;

  localparam int S   = 2;
  localparam int PER = S + 1;
`ifdef MISMATCH_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sequencer_if bus0();
  truth_table_sequencer_if bus1();

  truth_table_sequencer #(.SETTLE_CYCLES(S)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  logic [15:0] fn_cur   = 16'd0;
  logic [15:0] fn_ab_cd = 16'd0;

  // The expression under test is a lookup on the driven vector.
  always_comb bus0.y = fn_cur[bus0.abcd];
  always_comb bus1.y = fn_ab_cd[bus1.abcd];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model: position within a sweep ----------------
  bit          m_have = 1'b0;
  int          m_k = 0;
  int          m_done_k = 0;
  int          m_last = 15;
  logic [15:0] m_fn = 16'd0;
  logic [15:0] m_exp = 16'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 1'b0;
      m_k    = 0;
    end else if (!m_have || m_k > m_done_k) begin
      if (bus0.start) begin
        m_fn   = fn_cur;
        m_exp  = bus0.expected;
        m_last = 15;
        if (HALT && (m_fn ^ m_exp) != 16'd0)
          for (int i = 15; i >= 0; i--) if (m_fn[i] != m_exp[i]) m_last = i;
        m_done_k = (m_last + 1) * PER;
        m_k      = 0;
        m_have   = 1'b1;
      end
    end else begin
      m_k++;
    end
  end

  // Cycle k after acceptance: vector k/PER is applied, and k/PER vectors are already graded.
  always @(negedge clk) begin
    logic [15:0] mask, e_tt, e_mm;
    logic [3:0]  e_abcd, e_ff;
    logic        e_busy, e_done, e_pass;
    int          comp;
    e_tt = 16'd0; e_mm = 16'd0; e_abcd = 4'd0; e_ff = 4'd0;
    e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
    if (rst_n && m_have) begin
      comp = m_k / PER;
      if (comp > m_last + 1) comp = m_last + 1;
      mask = (comp >= 16) ? 16'hFFFF : 16'((32'd1 << comp) - 32'd1);
      e_tt = m_fn & mask;
      e_mm = (m_fn ^ m_exp) & mask;
      for (int i = 15; i >= 0; i--) if (e_mm[i]) e_ff = 4'(i);
      e_abcd = (m_k < m_done_k) ? 4'(m_k / PER) : 4'd0;
      e_busy = (m_k <= m_done_k);
      e_done = (m_k == m_done_k);
      e_pass = (m_k >= m_done_k) && (e_mm == 16'd0);
    end
    check("abcd", 32'(bus0.abcd), 32'(e_abcd));
    check("busy", 32'(bus0.busy), 32'(e_busy));
    check("done", 32'(bus0.done), 32'(e_done));
    check("pass", 32'(bus0.pass), 32'(e_pass));
    check("truth_table", 32'(bus0.truth_table), 32'(e_tt));
    check("mismatch_count", 32'(bus0.mismatch_count), 32'($countones(e_mm)));
    check("fail_valid", 32'(bus0.fail_valid), 32'(e_mm != 16'd0));
    check("first_fail_idx", 32'(bus0.first_fail_idx), 32'(e_ff));
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  // Returns the number of edges from acceptance to the done cycle; noisy re-starts optional.
  task automatic wait_done(input bit noise, output int n);
    n = 0;
    while (!bus0.done && n < 400) begin
      bus0.start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus0.start = 1'b0;
    if (n >= 400) check("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_results(input string tag, input logic [15:0] tt, input logic [4:0] cnt,
                               input logic [3:0] ff, input logic fv, input logic ps);
    check({tag, ".truth_table"}, 32'(bus0.truth_table), 32'(tt));
    check({tag, ".mismatch_count"}, 32'(bus0.mismatch_count), 32'(cnt));
    check({tag, ".first_fail_idx"}, 32'(bus0.first_fail_idx), 32'(ff));
    check({tag, ".fail_valid"}, 32'(bus0.fail_valid), 32'(fv));
    check({tag, ".pass"}, 32'(bus0.pass), 32'(ps));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, done_cnt, done_at;
    bus0.start = 1'b0; bus0.expected = 16'd0;
    bus1.start = 1'b0; bus1.expected = 16'hF888;
    for (int i = 0; i < 16; i++)
      fn_ab_cd[i] = (i[3] & i[2]) | (i[1] & i[0]);

    repeat (3) @(negedge clk);
    check("reset.busy", 32'(bus0.busy), 32'd0);
    check("reset.truth_table", 32'(bus0.truth_table), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Y = A&B | C&D against its correct table
    fn_cur = fn_ab_cd; bus0.expected = 16'hF888;
    pulse_start(); wait_done(1'b0, n);
    check("t31.latency", 32'(n), 32'd48);
    check_results("t31", 16'hF888, 5'd0, 4'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // single mismatch at vector 0
    bus0.expected = 16'hF889;
    pulse_start(); wait_done(1'b0, n);
    if (HALT) begin
      check("t32.latency", 32'(n), 32'd3);
      check_results("t32", 16'h0000, 5'd1, 4'd0, 1'b1, 1'b0);
    end else begin
      check("t32.latency", 32'(n), 32'd48);
      check_results("t32", 16'hF888, 5'd1, 4'd0, 1'b1, 1'b0);
    end
    repeat (2) @(negedge clk);

    // y tied low against all ones
    fn_cur = 16'h0000; bus0.expected = 16'hFFFF;
    pulse_start(); wait_done(1'b0, n);
    check_results("t33", 16'h0000, HALT ? 5'd1 : 5'd16, 4'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // re-pulsed start during a sweep is ignored
    fn_cur = fn_ab_cd; bus0.expected = 16'hF888;
    pulse_start();
    done_cnt = 0; done_at = -1;
    for (int k = 0; k < 60; k++) begin
      bus0.start = (k == 5 || k == 20);
      if (bus0.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    bus0.start = 1'b0;
    check("t34.done_pulses", 32'(done_cnt), 32'd1);
    check("t34.done_cycle", 32'(done_at), 32'd48);
    check_results("t34", 16'hF888, 5'd0, 4'd0, 1'b0, 1'b1);

    // reset mid-sweep clears everything at once, no done afterwards
    pulse_start();
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t35.abcd", 32'(bus0.abcd), 32'd0);
    check("t35.busy", 32'(bus0.busy), 32'd0);
    check("t35.done", 32'(bus0.done), 32'd0);
    check_results("t35.rst", 16'h0000, 5'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("t35.no_done", 32'(bus0.done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(); wait_done(1'b0, n);
    check("t35.latency", 32'(n), 32'd48);
    check_results("t35", 16'hF888, 5'd0, 4'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // randomized sweeps with start noise while busy
    for (int t = 0; t < 8; t++) begin
      fn_cur = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       bus0.expected = fn_cur;
        1:       bus0.expected = fn_cur ^ 16'(32'd1 << $urandom_range(0, 15));
        2:       bus0.expected = 16'($urandom);
        default: bus0.expected = ~fn_cur;
      endcase
      pulse_start(); wait_done(1'b1, n);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // SETTLE_CYCLES=1 instance: abcd walks 0..15 holding each value two cycles
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("t36.abcd", 32'(bus1.abcd), 32'(k / 2));
      @(negedge clk);
    end
    check("t36.abcd_end", 32'(bus1.abcd), 32'd0);
    check("t36.done", 32'(bus1.done), 32'd1);
    check("t36.pass", 32'(bus1.pass), 32'd1);
    @(negedge clk);
    check("t36.idle", 32'(bus1.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of cycles each input vector is held before Y is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin a sweep; honoured only in IDLE.
REQ-005 SHALL have port expected  input  16  golden truth table; bit i = expected Y for vector i.
REQ-006 SHALL have port abcd  output  4  driven vector to the expression under test; [3]=A, [2]=B, [1]=C, [0]=D.
REQ-007 SHALL have port y  input  1  combinational result from the expression under test.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL have port pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 SHALL have port truth_table  output  16  captured Y per vector.
REQ-012 SHALL have port mismatch_count  output  5  mismatches in current/last sweep (0..16).
REQ-013 SHALL have port first_fail_idx  output  4  index of first mismatching vector; valid only when fail_valid is high.
REQ-014 SHALL have port fail_valid  output  1  high once any mismatch is recorded in the current/last sweep.

Function
REQ-015 SHALL implement states IDLE, APPLY, SAMPLE, DONE.
REQ-016 IDLE with start=1 at an edge SHALL move to APPLY, set index=0, settle counter=0, and clear truth_table, mismatch_count, fail_valid, first_fail_idx and pass.
REQ-017 start while busy=1 SHALL be ignored with no effect on the sweep.
REQ-018 abcd SHALL equal the current index in APPLY and SAMPLE, and 4'h0 in IDLE and DONE.
REQ-019 APPLY SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-020 The edge leaving SAMPLE SHALL write y into truth_table[index] and compare it with expected[index].
REQ-021 On mismatch SHALL increment mismatch_count; if fail_valid was 0, SHALL set fail_valid=1 and first_fail_idx=index.
REQ-022 SAMPLE with index<15 SHALL go to APPLY with index+1; with index=15 SHALL go to DONE.
REQ-023 Each vector SHALL take SETTLE_CYCLES+1 cycles; done SHALL be high in the cycle following the start-acceptance edge + 16*(SETTLE_CYCLES+1) edges.
REQ-024 DONE SHALL assert done for one cycle, set pass = (mismatch_count==0), and return to IDLE on the next edge.
REQ-025 Results SHALL hold stable in IDLE until the next accepted start.
REQ-026 Index SHALL never wrap; the sweep ends at 15.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, abcd=0, busy=0, done=0, pass=0, truth_table=0, mismatch_count=0, first_fail_idx=0, fail_valid=0, independent of clk.
REQ-028 Reset mid-sweep SHALL abort the sweep with no done pulse; the first edge after release SHALL observe IDLE.

Configuration
REQ-029 Macro MISMATCH_HALT_EN defined: the first mismatch in SAMPLE SHALL go directly to DONE (mismatch_count=1, pass=0, uncaptured truth_table bits remain 0).
REQ-030 MISMATCH_HALT_EN undefined: all 16 vectors SHALL always be swept regardless of mismatches.

Verification
REQ-031 DUT Y=A&B|C&D, expected=16'hF888, SETTLE_CYCLES=2, pulse start -> done after 48 cycles, truth_table=16'hF888, pass=1, mismatch_count=0, fail_valid=0.
REQ-032 Same DUT, expected=16'hF889 -> pass=0, mismatch_count=1, first_fail_idx=0, fail_valid=1 (halt build: done after 3 cycles).
REQ-033 y tied 0, expected=16'hFFFF, halt disabled -> truth_table=0, mismatch_count=16, first_fail_idx=0, pass=0.
REQ-034 start re-pulsed at cycles 5 and 20 of a sweep -> single done pulse at cycle 48, results unchanged from REQ-031.
REQ-035 rst_n low at cycle 17 of a sweep -> all outputs 0 immediately, no done; new start after release gives REQ-031 results.
REQ-036 SETTLE_CYCLES=1, abcd monitored -> sequence 0..15, each value held 2 cycles, then 0.
